unary_operand_driver: RTL and testbench

- Upstream stage of the mod-6 unary adder: converts two binary digits into the adder's unary operand streams A/B and sequences its control lines en/read_or_write.
- Accepts one digit pair per transaction over a valid/ready handshake.
- Runs a read phase that drives the unary pulses, then a write (drain) phase that lets the adder emit its unary result on dout.
- Signals completion with a one-cycle done pulse.

---
 rtl/unary_operand_driver.sv | 148 ++++++++++++++
 tb/tb_unary_operand_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/unary_operand_driver.sv
// Converts a binary digit pair into unary A/B pulse streams and sequences en/read_or_write for the mod-6 unary adder.
// Optional build macro: UNARY_DRV_STALL_EN adds a stall input that freezes the READ/DRAIN phases.
module unary_operand_driver #(
    parameter int DIGIT_W      = 3,
    parameter int MAX_DIGIT    = 5,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef UNARY_DRV_STALL_EN
    input  logic               stall,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               A,
    output logic               B,
    output logic               en,
    output logic               read_or_write,
    output logic               busy,
    output logic               done,
    output logic               clamp_err
);
    localparam int CNT_MAX = (MAX_DIGIT > DRAIN_CYCLES) ? MAX_DIGIT : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIGIT_W-1:0] MAX_D      = DIGIT_W'(MAX_DIGIT);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [CNT_W-1:0]   r_ca, r_cb, w_ca_n, w_cb_n;
    logic               r_clamp, w_clamp_n;
    logic               r_a, r_b, r_en, r_rw, r_busy, r_done;
    logic               w_a_n, w_b_n, w_en_n, w_rw_n, w_busy_n, w_done_n;
    logic               w_hold, w_stall;
    logic               w_a_clip, w_b_clip;
    logic [CNT_W-1:0]   w_ca_in, w_cb_in, w_len_in, w_len;

`ifdef UNARY_DRV_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_a_clip = (a_digit > MAX_D);
    assign w_b_clip = (b_digit > MAX_D);
    assign w_ca_in  = w_a_clip ? CNT_W'(MAX_D) : CNT_W'(a_digit);
    assign w_cb_in  = w_b_clip ? CNT_W'(MAX_D) : CNT_W'(b_digit);
    assign w_len_in = (w_ca_in > w_cb_in) ? w_ca_in : w_cb_in;
    assign w_len    = (r_ca > r_cb) ? r_ca : r_cb;

    assign in_ready = (r_state == S_IDLE);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ca_n    = r_ca;
        w_cb_n    = r_cb;
        w_clamp_n = r_clamp;
        w_hold    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_ca_n    = w_ca_in;
                    w_cb_n    = w_cb_in;
                    w_clamp_n = r_clamp | w_a_clip | w_b_clip;
                    w_state_n = (w_len_in != '0) ? S_READ : S_DRAIN;
                    w_cnt_n   = '0;
                end
            end
            S_READ: begin
                if (w_stall) begin
                    w_hold = 1'b1;
                end else if (r_cnt == w_len - CNT_W'(1)) begin
                    w_state_n = S_DRAIN;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (w_stall) begin
                    w_hold = 1'b1;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_state_n = S_DONE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the flops present each cycle's values right after the edge.
        w_busy_n = (w_state_n == S_READ) || (w_state_n == S_DRAIN);
        w_en_n   = w_busy_n && !w_hold;
        w_rw_n   = (w_state_n == S_DRAIN);
        w_a_n    = (w_state_n == S_READ) && !w_hold && (w_cnt_n < w_ca_n);
        w_b_n    = (w_state_n == S_READ) && !w_hold && (w_cnt_n < w_cb_n);
        w_done_n = (w_state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ca    <= '0;
            r_cb    <= '0;
            r_clamp <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_en    <= 1'b0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ca    <= w_ca_n;
            r_cb    <= w_cb_n;
            r_clamp <= w_clamp_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_en    <= w_en_n;
            r_rw    <= w_rw_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign A             = r_a;
    assign B             = r_b;
    assign en            = r_en;
    assign read_or_write = r_rw;
    assign busy          = r_busy;
    assign done          = r_done;
    assign clamp_err     = r_clamp;
endmodule

// File: tb/tb_unary_operand_driver.sv
// Table-driven directed bench for unary_operand_driver: one row per clock cycle, plus a mid-transaction reset sequence.
module tb_unary_operand_driver;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a_digit;
    logic [2:0] b_digit;
    logic       A, B, en, read_or_write, busy, done, clamp_err;

    int total = 0;
    int bad   = 0;

    unary_operand_driver #(
        .DIGIT_W      (3),
        .MAX_DIGIT    (5),
        .DRAIN_CYCLES (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef UNARY_DRV_STALL_EN
        .stall         (1'b0),
`endif
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_digit       (a_digit),
        .b_digit       (b_digit),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .busy          (busy),
        .done          (done),
        .clamp_err     (clamp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector order: {in_ready, A, B, en, read_or_write, busy, done}
    localparam logic [6:0] IDL = 7'b1000000;
    localparam logic [6:0] R11 = 7'b0111010;
    localparam logic [6:0] R10 = 7'b0101010;
    localparam logic [6:0] R01 = 7'b0011010;
    localparam logic [6:0] DRN = 7'b0001110;
    localparam logic [6:0] DNE = 7'b0000001;

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic [2:0] b;
        logic [6:0] exp;
        logic       clamp;
    } row_t;

    row_t rows[$];

    task automatic add(input logic v, input logic [2:0] a, input logic [2:0] b,
                       input logic [6:0] e, input logic c);
        row_t r;
        r.v = v; r.a = a; r.b = b; r.exp = e; r.clamp = c;
        rows.push_back(r);
    endtask

    task automatic add_n(input int n, input logic v, input logic [2:0] a, input logic [2:0] b,
                         input logic [6:0] e, input logic c);
        for (int k = 0; k < n; k++) add(v, a, b, e, c);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%b want=%b", name, idx, got, want);
        end
    endtask

    function automatic logic [7:0] sample();
        return {in_ready, A, B, en, read_or_write, busy, done, clamp_err};
    endfunction

    task automatic run_rows(input int first);
        for (int i = first; i < rows.size(); i++) begin
            in_valid = rows[i].v;
            a_digit  = rows[i].a;
            b_digit  = rows[i].b;
            @(posedge clk);
            @(negedge clk);
            check("row", i, sample(), {rows[i].exp, rows[i].clamp});
        end
    endtask

    initial begin
        int start;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_digit  = '0;
        b_digit  = '0;

        // a=2,b=3: three READ cycles, six DRAIN, DONE, then IDLE
        add(1, 3'd2, 3'd3, R11, 0);
        add(0, 3'd0, 3'd0, R11, 0);
        add(0, 3'd0, 3'd0, R01, 0);
        add_n(6, 0, 3'd0, 3'd0, DRN, 0);
        add(0, 3'd0, 3'd0, DNE, 0);
        add(0, 3'd0, 3'd0, IDL, 0);
        // a=0,b=0: straight to DRAIN
        add(1, 3'd0, 3'd0, DRN, 0);
        add_n(5, 0, 3'd0, 3'd0, DRN, 0);
        add(0, 3'd0, 3'd0, DNE, 0);
        add(0, 3'd0, 3'd0, IDL, 0);
        // in_valid held high with changing digits: only first pair used
        add(1, 3'd1, 3'd0, R10, 0);
        add_n(3, 1, 3'd4, 3'd4, DRN, 0);
        add_n(3, 1, 3'd5, 3'd2, DRN, 0);
        add(1, 3'd3, 3'd3, DNE, 0);
        add(1, 3'd3, 3'd2, IDL, 0);
        add(1, 3'd3, 3'd2, R11, 0);
        add(0, 3'd0, 3'd0, R11, 0);
        add(0, 3'd0, 3'd0, R10, 0);
        add_n(6, 0, 3'd0, 3'd0, DRN, 0);
        add(0, 3'd0, 3'd0, DNE, 0);
        add(0, 3'd0, 3'd0, IDL, 0);
        // a=5 is exactly MAX_DIGIT: not clamped
        add(1, 3'd5, 3'd0, R10, 0);
        add_n(4, 0, 3'd0, 3'd0, R10, 0);
        add_n(6, 0, 3'd0, 3'd0, DRN, 0);
        add(0, 3'd0, 3'd0, DNE, 0);
        add(0, 3'd0, 3'd0, IDL, 0);
        // a=7 clamps to 5; clamp_err sticks after done
        add(1, 3'd7, 3'd5, R11, 1);
        add_n(4, 0, 3'd0, 3'd0, R11, 1);
        add_n(6, 0, 3'd0, 3'd0, DRN, 1);
        add(0, 3'd0, 3'd0, DNE, 1);
        add_n(2, 0, 3'd0, 3'd0, IDL, 1);

        #12;
        total++;
        if ({A, B, en, read_or_write, busy, done, clamp_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_vals got=%b want=%b",
                     {A, B, en, read_or_write, busy, done, clamp_err}, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", 0, sample(), {IDL, 1'b0});

        run_rows(0);

        // Reset pulsed during the third DRAIN cycle of a=1,b=1
        in_valid = 1'b1; a_digit = 3'd1; b_digit = 3'd1;
        @(posedge clk); @(negedge clk);
        check("rst_seq_read", 0, sample(), {R11, 1'b1});
        in_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); @(negedge clk);
            check("rst_seq_drain", k, sample(), {DRN, 1'b1});
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({A, B, en, read_or_write, busy, done, clamp_err} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b",
                     {A, B, en, read_or_write, busy, done, clamp_err}, 7'b0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after_rst", 0, sample(), {IDL, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            check("after_rst", k, sample(), {IDL, 1'b0});
        end

        // Next transaction after the aborted one runs normally
        start = rows.size();
        add(1, 3'd0, 3'd2, R01, 0);
        add(0, 3'd0, 3'd0, R01, 0);
        add_n(6, 0, 3'd0, 3'd0, DRN, 0);
        add(0, 3'd0, 3'd0, DNE, 0);
        add(0, 3'd0, 3'd0, IDL, 0);
        run_rows(start);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
